// File: rtl/clock_seq_pkg.sv
// Shared types and sizing helpers for the clock enable sequencer.
// Holds the FSM state enum and the counter/index width functions.
package clock_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE_ON,
    SETTLE_OFF
  } seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_seq_rr_arbiter.sv
// Rotate-priority pick: first set bit of pend_i at or after ptr_i.
// Ports: pend_i, ptr_i in; gnt_o (one-hot), idx_o, vld_o out.
module clock_seq_rr_arbiter
  import clock_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              pend_i,
  input  logic [idx_width(N)-1:0]   ptr_i,
  output logic [N-1:0]              gnt_o,
  output logic [idx_width(N)-1:0]   idx_o,
  output logic                      vld_o
);

  localparam int unsigned PW = idx_width(N);

  logic [PW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = PW'((32'(ptr_i) + i) % N);
      if (!vld_o && pend_i[j]) begin
        vld_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_enable_sequencer.sv
// Sequences per-domain clock enables one transition at a time.
// Ports: clk_i, rst_ni, req_i in; en_o, ack_o, busy_o out;
// idle_i in only when CLKSEQ_IDLE_TIMEOUT_EN is defined.
module clock_enable_sequencer
  import clock_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] req_i,
`ifdef CLKSEQ_IDLE_TIMEOUT_EN
  input  logic [NUM_DOMAINS-1:0] idle_i,
`endif
  output logic [NUM_DOMAINS-1:0] en_o,
  output logic [NUM_DOMAINS-1:0] ack_o,
  output logic                   busy_o
);

  localparam int unsigned CW = cnt_width(SETTLE_CYCLES);
  localparam int unsigned PW = idx_width(NUM_DOMAINS);

  seq_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] en_q, en_d;
  logic [NUM_DOMAINS-1:0] ack_q, ack_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          cur_q, cur_d;

  logic [NUM_DOMAINS-1:0] eff_req;
  logic [NUM_DOMAINS-1:0] pend;
  logic [NUM_DOMAINS-1:0] gnt;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_vld;

`ifdef CLKSEQ_IDLE_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);

  logic [NUM_DOMAINS-1:0][TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [NUM_DOMAINS-1:0]         expired_q, expired_d;

  // Expired stays set after the turn-off clears the counter,
  // until the domain shows activity or drops its request.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    expired_d  = expired_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (!(ack_q[i] && idle_i[i])) begin
        idle_cnt_d[i] = '0;
      end else if (idle_cnt_q[i] != TW'(TIMEOUT_CYCLES)) begin
        idle_cnt_d[i] = idle_cnt_q[i] + 1'b1;
      end
      if (!idle_i[i] || !req_i[i]) begin
        expired_d[i] = 1'b0;
      end else if (idle_cnt_q[i] == TW'(TIMEOUT_CYCLES)) begin
        expired_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= '0;
      expired_q  <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      expired_q  <= expired_d;
    end
  end

  assign eff_req = req_i & ~expired_q;
`else
  assign eff_req = req_i;
`endif

  assign pend = eff_req ^ ack_q;

  clock_seq_rr_arbiter #(
    .N (NUM_DOMAINS)
  ) u_arb (
    .pend_i (pend),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .vld_o  (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ack_d   = ack_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          cur_d = gnt_idx;
          cnt_d = CW'(SETTLE_CYCLES - 1);
          ptr_d = (gnt_idx == PW'(NUM_DOMAINS - 1)) ?
                  '0 : gnt_idx + 1'b1;
          // Turn-on raises en first; turn-off drops ack first.
          if (|(eff_req & gnt)) begin
            en_d    = en_q | gnt;
            state_d = SETTLE_ON;
          end else begin
            ack_d   = ack_q & ~gnt;
            state_d = SETTLE_OFF;
          end
        end
      end
      SETTLE_ON: begin
        if (cnt_q == '0) begin
          ack_d[cur_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE_OFF: begin
        if (cnt_q == '0) begin
          en_d[cur_q] = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
    end
  end

  assign en_o   = en_q;
  assign ack_o  = ack_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Self-checking bench for clock_enable_sequencer.
// Event-scheduled reference model plus directed timing checks.
module tb_clock_enable_sequencer;

  localparam int N = 4;
  localparam int S = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] idle  = '0;
  logic [N-1:0] en;
  logic [N-1:0] ack;
  logic         busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  clock_enable_sequencer #(
    .NUM_DOMAINS    (N),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
`ifdef CLKSEQ_IDLE_TIMEOUT_EN
    .idle_i (idle),
`endif
    .en_o   (en),
    .ack_o  (ack),
    .busy_o (busy)
  );

  // Model: a grant at cycle c schedules the first output change
  // at c+1 and the second at c+1+S; the arbiter is free again
  // at c+1+S.
  typedef struct {
    int t;
    int d;
    bit is_en;
    bit v;
  } ev_t;

  ev_t          evq[$];
  logic [N-1:0] m_en;
  logic [N-1:0] m_ack;
  int           cyc;
  int           ptr;
  int           busy_lo;
  int           next_free;

  task automatic model_reset();
    evq.delete();
    m_en      = '0;
    m_ack     = '0;
    cyc       = 0;
    ptr       = 0;
    busy_lo   = 0;
    next_free = 0;
  endtask

  task automatic model_apply();
    ev_t keep[$];
    foreach (evq[i]) begin
      if (evq[i].t == cyc) begin
        if (evq[i].is_en) m_en[evq[i].d] = evq[i].v;
        else              m_ack[evq[i].d] = evq[i].v;
      end else begin
        keep.push_back(evq[i]);
      end
    end
    evq = keep;
  endtask

  task automatic model_decide(input logic [N-1:0] r);
    logic [N-1:0] pend;
    int           d;
    bit           found;
    if (cyc >= next_free) begin
      pend  = r ^ m_ack;
      found = 0;
      for (int o = 0; o < N; o++) begin
        d = (ptr + o) % N;
        if (!found && pend[d]) begin
          found = 1;
          if (r[d]) begin
            evq.push_back('{cyc + 1, d, 1'b1, 1'b1});
            evq.push_back('{cyc + 1 + S, d, 1'b0, 1'b1});
          end else begin
            evq.push_back('{cyc + 1, d, 1'b0, 1'b0});
            evq.push_back('{cyc + 1 + S, d, 1'b1, 1'b0});
          end
          busy_lo   = cyc + 1;
          next_free = cyc + 1 + S;
          ptr       = (d + 1) % N;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    logic exp_b;
    req = r;
    @(negedge clk);
    model_apply();
    exp_b = (cyc >= busy_lo) && (cyc < next_free);
    vectors++;
    if (en !== m_en) begin
      errors++;
      $display("FAIL en c%0d: got %b want %b", cyc, en, m_en);
    end
    vectors++;
    if (ack !== m_ack) begin
      errors++;
      $display("FAIL ack c%0d: got %b want %b", cyc, ack, m_ack);
    end
    vectors++;
    if (busy !== exp_b) begin
      errors++;
      $display("FAIL busy c%0d: got %b want %b", cyc, busy, exp_b);
    end
    vectors++;
    if (((ack & ~en) != '0) || ($countones(en ^ ack) > 1)) begin
      errors++;
      $display("FAIL invariant c%0d: en %b ack %b want ack<=en, <=1 in flight",
               cyc, en, ack);
    end
    model_decide(r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req   = '0;
    idle  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({en, ack, busy} !== '0) begin
      errors++;
      $display("FAIL reset: got en %b ack %b busy %b want 0",
               en, ack, busy);
    end
    do_reset();
  endtask

  task automatic test_single_on();
    int t_en;
    int t_ack;
    do_reset();
    t_en  = -1;
    t_ack = -1;
    repeat (12) begin
      step(4'b0001);
      if (en[0] && t_en < 0) t_en = cyc;
      if (ack[0] && t_ack < 0) t_ack = cyc;
    end
    vectors++;
    if (t_en !== 1) begin
      errors++;
      $display("FAIL single_en_cycle: got %0d want 1", t_en);
    end
    vectors++;
    if (t_ack !== 9) begin
      errors++;
      $display("FAIL single_ack_cycle: got %0d want 9", t_ack);
    end
  endtask

  task automatic test_all_on_off();
    int rise[N];
    int afall[N];
    int efall[N];
    int t_all;
    do_reset();
    t_all = -1;
    for (int i = 0; i < N; i++) rise[i] = -1;
    repeat (40) begin
      step(4'b1111);
      for (int i = 0; i < N; i++)
        if (en[i] && rise[i] < 0) rise[i] = cyc;
      if (ack == 4'b1111 && t_all < 0) t_all = cyc;
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (rise[i] !== 1 + 9 * i) begin
        errors++;
        $display("FAIL all_on_rise[%0d]: got %0d want %0d",
                 i, rise[i], 1 + 9 * i);
      end
    end
    vectors++;
    if (t_all !== 36) begin
      errors++;
      $display("FAIL all_on_ack: got %0d want 36", t_all);
    end
    for (int i = 0; i < N; i++) begin
      afall[i] = -1;
      efall[i] = -1;
    end
    repeat (40) begin
      step(4'b0000);
      for (int i = 0; i < N; i++) begin
        if (!ack[i] && afall[i] < 0) afall[i] = cyc;
        if (!en[i] && efall[i] < 0) efall[i] = cyc;
      end
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (efall[i] - afall[i] !== S) begin
        errors++;
        $display("FAIL all_off_gap[%0d]: got %0d want %0d",
                 i, efall[i] - afall[i], S);
      end
    end
  endtask

  task automatic test_pulse();
    int   rises;
    int   acks;
    logic prev;
    do_reset();
    rises = 0;
    acks  = 0;
    prev  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(k < 3 ? 4'b0100 : 4'b0000);
      if (en[2] && !prev) rises++;
      if (ack[2]) acks++;
      prev = en[2];
    end
    vectors++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL pulse_en_rises: got %0d want 1", rises);
    end
    vectors++;
    if (acks !== 1 || en[2] !== 1'b0) begin
      errors++;
      $display("FAIL pulse_complete: got acks %0d en %b want 1 0",
               acks, en[2]);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    repeat (3) step(4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({en, ack, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: got en %b ack %b busy %b want 0",
               en, ack, busy);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step(4'b0011);
    vectors++;
    if (en !== 4'b0001) begin
      errors++;
      $display("FAIL restart_ptr: got en %b want 0001", en);
    end
    repeat (25) step(4'b0011);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    r = '0;
    repeat (600) begin
      if ($urandom_range(5) == 0) r = N'($urandom);
      step(r);
    end
  endtask

`ifdef CLKSEQ_IDLE_TIMEOUT_EN
  task automatic test_idle_timeout();
    int n;
    do_reset();
    repeat (10) step(4'b0001);
    idle[0] = 1'b1;
    n = 0;
    while (ack[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (ack[0] !== 1'b0 || req[0] !== 1'b1 || n < 16 || n > 20) begin
      errors++;
      $display("FAIL idle_off: got ack %b after %0d want 0 in 16..20",
               ack[0], n);
    end
    repeat (S) @(posedge clk);
    #1;
    vectors++;
    if (en[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_en_off: got %b want 0", en[0]);
    end
    idle[0] = 1'b0;
    n = 0;
    while (!ack[0] && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL idle_rearm: got ack %b want 1", ack[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_on();
    test_all_on_off();
    test_pulse();
    test_reset_abort();
    test_random();
`ifdef CLKSEQ_IDLE_TIMEOUT_EN
    test_idle_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
